// File: rtl/branch_resolve_feedback.sv
// EX-side branch resolution: queues in-flight IF predictions, compares each against
// the EX outcome, returns predictor feedback and raises a flush on mispredict.
module branch_resolve_feedback #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pred_valid,
   input  logic                       pred_take,
   input  logic [31:0]                pred_pc_base,
   input  logic [31:0]                pred_pc_jmp,
   output logic                       pred_ready,
   input  logic                       ex_valid,
   input  logic                       ex_take,
   input  logic [31:0]                ex_target,
   output logic                       pc_jmp_feedback,
   output logic                       pc_jmp_take,
   output logic [31:0]                pc_stash_base,
   output logic [31:0]                pc_jmp,
   output logic                       flush,
   output logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           resolved_cnt,
   output logic [CNT_W-1:0]           mispredict_cnt,
   output logic                       err_overflow,
   output logic                       err_underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic              q_take [DEPTH];
   logic [31:0]       q_base [DEPTH];
   logic [31:0]       q_jmp  [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [OCC_W-1:0]  count;

   logic              full;
   logic              do_pop;
   logic              do_push;
   logic              mispredict;
   logic              head_take;
   logic [31:0]       head_base;
   logic [31:0]       head_jmp;

   assign full       = (count == OCC_W'(DEPTH));
   assign pred_ready = !full;
   assign occupancy  = count;

   assign head_take  = q_take[head];
   assign head_base  = q_base[head];
   assign head_jmp   = q_jmp[head];

   assign do_pop     = ex_valid && (count != '0);
   assign mispredict = do_pop && ((head_take != ex_take) || (ex_take && (head_jmp != ex_target)));
   // A pop frees the head slot, so a push into a full queue is accepted alongside it;
   // anything pushed in a mispredict cycle is wrong-path and is dropped.
   assign do_push    = pred_valid && (!full || do_pop) && !mispredict;

   always_ff @(posedge clk) begin
      if (do_push) begin
         q_take[tail] <= pred_take;
         q_base[tail] <= pred_pc_base;
         q_jmp[tail]  <= pred_pc_jmp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (mispredict) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_pop)
            head <= head + PTR_W'(1);
         if (do_push)
            tail <= tail + PTR_W'(1);
         if (do_push && !do_pop)
            count <= count + OCC_W'(1);
         else if (do_pop && !do_push)
            count <= count - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_jmp_feedback <= 1'b0;
         pc_jmp_take     <= 1'b0;
         pc_stash_base   <= '0;
         pc_jmp          <= '0;
         flush           <= 1'b0;
         redirect_pc     <= '0;
         resolved_cnt    <= '0;
         mispredict_cnt  <= '0;
      end else begin
         pc_jmp_feedback <= do_pop;
         flush           <= mispredict;
         redirect_pc     <= '0;
         if (do_pop) begin
            pc_jmp_take   <= ex_take;
            pc_stash_base <= head_base;
            pc_jmp        <= ex_target;
            if (resolved_cnt != '1)
               resolved_cnt <= resolved_cnt + CNT_W'(1);
         end
         if (mispredict) begin
            redirect_pc <= ex_take ? ex_target : (head_base + 32'd4);
            if (mispredict_cnt != '1)
               mispredict_cnt <= mispredict_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (pred_valid && full && !do_pop)
            err_overflow <= 1'b1;
         if (ex_valid && (count == '0))
            err_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_feedback.sv
// Scoreboard bench for branch_resolve_feedback: a queue-based reference model predicts
// every feedback pulse, and a separate monitor compares whatever the DUT presents.
module tb_branch_resolve_feedback;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  pred_valid = 1'b0;
   logic                  pred_take = 1'b0;
   logic [31:0]           pred_pc_base = '0;
   logic [31:0]           pred_pc_jmp = '0;
   logic                  pred_ready;
   logic                  ex_valid = 1'b0;
   logic                  ex_take = 1'b0;
   logic [31:0]           ex_target = '0;
   logic                  pc_jmp_feedback;
   logic                  pc_jmp_take;
   logic [31:0]           pc_stash_base;
   logic [31:0]           pc_jmp;
   logic                  flush;
   logic [31:0]           redirect_pc;
   logic [$clog2(DEPTH):0] occupancy;
   logic [CNT_W-1:0]      resolved_cnt;
   logic [CNT_W-1:0]      mispredict_cnt;
   logic                  err_overflow;
   logic                  err_underflow;

   branch_resolve_feedback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_take(pred_take),
      .pred_pc_base(pred_pc_base), .pred_pc_jmp(pred_pc_jmp), .pred_ready(pred_ready),
      .ex_valid(ex_valid), .ex_take(ex_take), .ex_target(ex_target),
      .pc_jmp_feedback(pc_jmp_feedback), .pc_jmp_take(pc_jmp_take),
      .pc_stash_base(pc_stash_base), .pc_jmp(pc_jmp),
      .flush(flush), .redirect_pc(redirect_pc), .occupancy(occupancy),
      .resolved_cnt(resolved_cnt), .mispredict_cnt(mispredict_cnt),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        take;
      logic [31:0] base;
      logic [31:0] jmp;
   } pred_t;

   typedef struct {
      int          due;
      logic        take;
      logic [31:0] base;
      logic [31:0] jmp;
      logic        flush;
      logic [31:0] redirect;
      int          resolved;
      int          mis;
   } exp_t;

   pred_t mq[$];
   exp_t  sb[$];
   int    m_res = 0;
   int    m_mis = 0;
   bit    m_ovf = 0;
   bit    m_unf = 0;
   int    edge_n = 0;
   int    checks = 0;
   int    errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference behaviour: a list of outstanding predictions resolved strictly in order.
   task automatic modelStep(input bit pv, input bit pt, input logic [31:0] pb, input logic [31:0] pj,
                            input bit ev, input bit et, input logic [31:0] etg);
      exp_t  e;
      pred_t h;
      pred_t n;
      bit    popped = 0;
      bit    wrong = 0;
      int    size_before = mq.size();
      if (ev && size_before == 0)
         m_unf = 1;
      if (ev && size_before > 0) begin
         h = mq.pop_front();
         popped = 1;
         wrong = (h.take != et) || (et && h.jmp != etg);
         m_res = (m_res < CMAX) ? m_res + 1 : CMAX;
         if (wrong)
            m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
         e.due = edge_n + 1;
         e.take = et;
         e.base = h.base;
         e.jmp = etg;
         e.flush = wrong;
         e.redirect = !wrong ? 32'd0 : (et ? etg : h.base + 32'd4);
         e.resolved = m_res;
         e.mis = m_mis;
         sb.push_back(e);
      end
      if (wrong)
         mq.delete();
      else if (pv) begin
         if (size_before < DEPTH || popped) begin
            n.take = pt;
            n.base = pb;
            n.jmp = pj;
            mq.push_back(n);
         end else
            m_ovf = 1;
      end
   endtask

   task automatic applyStimulus(input bit pv, input bit pt, input logic [31:0] pb, input logic [31:0] pj,
                                input bit ev, input bit et, input logic [31:0] etg);
      @(negedge clk);
      pred_valid = pv; pred_take = pt; pred_pc_base = pb; pred_pc_jmp = pj;
      ex_valid = ev; ex_take = et; ex_target = etg;
      modelStep(pv, pt, pb, pj, ev, et, etg);
      @(posedge clk);
      #2;
      checkOutput("occupancy", 32'(occupancy), mq.size());
      checkOutput("pred_ready", 32'(pred_ready), (mq.size() < DEPTH) ? 1 : 0);
      checkOutput("err_overflow", 32'(err_overflow), 32'(m_ovf));
      checkOutput("err_underflow", 32'(err_underflow), 32'(m_unf));
   endtask

   task automatic checkReset();
      checkOutput("rst_feedback", 32'(pc_jmp_feedback), 0);
      checkOutput("rst_take", 32'(pc_jmp_take), 0);
      checkOutput("rst_base", pc_stash_base, 0);
      checkOutput("rst_jmp", pc_jmp, 0);
      checkOutput("rst_flush", 32'(flush), 0);
      checkOutput("rst_redirect", redirect_pc, 0);
      checkOutput("rst_occupancy", 32'(occupancy), 0);
      checkOutput("rst_resolved", 32'(resolved_cnt), 0);
      checkOutput("rst_mispredict", 32'(mispredict_cnt), 0);
      checkOutput("rst_overflow", 32'(err_overflow), 0);
      checkOutput("rst_underflow", 32'(err_underflow), 0);
      checkOutput("rst_pred_ready", 32'(pred_ready), 1);
   endtask

   // Monitor: every cycle either the scoreboard predicts a resolution or the pulses stay low.
   always @(posedge clk) begin
      exp_t e;
      #1;
      edge_n++;
      if (sb.size() > 0 && sb[0].due == edge_n) begin
         e = sb.pop_front();
         checkOutput("fb_pulse", 32'(pc_jmp_feedback), 1);
         checkOutput("fb_take", 32'(pc_jmp_take), 32'(e.take));
         checkOutput("fb_base", pc_stash_base, e.base);
         checkOutput("fb_jmp", pc_jmp, e.jmp);
         checkOutput("fb_flush", 32'(flush), 32'(e.flush));
         checkOutput("fb_redirect", redirect_pc, e.redirect);
         checkOutput("fb_resolved", 32'(resolved_cnt), e.resolved);
         checkOutput("fb_mispredict", 32'(mispredict_cnt), e.mis);
      end else begin
         checkOutput("idle_feedback", 32'(pc_jmp_feedback), 0);
         checkOutput("idle_flush", 32'(flush), 0);
      end
   end

   initial begin
      bit          pv, pt, ev, et;
      logic [31:0] pb, pj, etg;

      #12;
      checkReset();
      @(negedge clk);
      reset = 1'b0;

      // Correct taken prediction
      applyStimulus(1, 1, 32'h100, 32'h200, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h200);
      checkOutput("t1_feedback", 32'(pc_jmp_feedback), 1);
      checkOutput("t1_base", pc_stash_base, 32'h100);
      checkOutput("t1_jmp", pc_jmp, 32'h200);
      checkOutput("t1_flush", 32'(flush), 0);
      checkOutput("t1_resolved", 32'(resolved_cnt), 1);
      checkOutput("t1_mispredict", 32'(mispredict_cnt), 0);

      // Direction mispredict: fall through to base+4
      applyStimulus(1, 1, 32'h140, 32'h180, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h144);
      checkOutput("t2_flush", 32'(flush), 1);
      checkOutput("t2_redirect", redirect_pc, 32'h144);
      checkOutput("t2_occupancy", 32'(occupancy), 0);
      checkOutput("t2_mispredict", 32'(mispredict_cnt), 1);

      // Target mispredict
      applyStimulus(1, 1, 32'h2F0, 32'h300, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h304);
      checkOutput("t3_flush", 32'(flush), 1);
      checkOutput("t3_redirect", redirect_pc, 32'h304);

      // Fill, overflow, then push+pop while full
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1, 1, 32'h400 + 32'(16 * i), 32'h800 + 32'(16 * i), 0, 0, 0);
      checkOutput("t4_ready_full", 32'(pred_ready), 0);
      applyStimulus(1, 1, 32'h500, 32'h540, 0, 0, 0);
      checkOutput("t4_overflow", 32'(err_overflow), 1);
      checkOutput("t4_occ_full", 32'(occupancy), 4);
      applyStimulus(1, 0, 32'h600, 32'h700, 1, 1, 32'h800);
      checkOutput("t4_occ_pushpop", 32'(occupancy), 4);
      for (int i = 1; i < DEPTH; i++)
         applyStimulus(0, 0, 0, 0, 1, 1, 32'h800 + 32'(16 * i));
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h604);
      checkOutput("t4_tail_base", pc_stash_base, 32'h600);
      checkOutput("t4_tail_flush", 32'(flush), 0);

      // Mispredict with a simultaneous push, then resolve on empty
      applyStimulus(1, 1, 32'h900, 32'hA00, 0, 0, 0);
      applyStimulus(1, 1, 32'h980, 32'hA80, 0, 0, 0);
      applyStimulus(1, 1, 32'hB00, 32'hC00, 1, 0, 32'h904);
      checkOutput("t5_occ_flushed", 32'(occupancy), 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h123);
      checkOutput("t5_underflow", 32'(err_underflow), 1);
      checkOutput("t5_no_pulse", 32'(pc_jmp_feedback), 0);

      // Fall-through address wraps
      applyStimulus(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
      checkOutput("t6_redirect_wrap", redirect_pc, 32'h0);
      checkOutput("t6_flush_wrap", 32'(flush), 1);

      // Asynchronous reset with entries queued
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 1, 32'h1000 + 32'(8 * i), 32'h2000, 0, 0, 0);
      #1;
      reset = 1'b1;
      #1;
      mq.delete();
      sb.delete();
      m_res = 0; m_mis = 0; m_ovf = 0; m_unf = 0;
      checkReset();
      @(negedge clk);
      pred_valid = 0; ex_valid = 0;
      reset = 1'b0;

      // Randomized traffic, mostly-correct resolutions so the queue fills and drains
      for (int k = 0; k < 600; k++) begin
         pv = ($urandom_range(0, 99) < 60);
         pt = $urandom_range(0, 1) == 1;
         pb = $urandom & 32'hFFFF_FFFC;
         pj = $urandom & 32'hFFFF_FFFC;
         ev = ($urandom_range(0, 99) < 50);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            et = mq[0].take;
            etg = mq[0].take ? mq[0].jmp : ($urandom & 32'hFFFF_FFFC);
         end else begin
            et = $urandom_range(0, 1) == 1;
            etg = $urandom & 32'hFFFF_FFFC;
         end
         applyStimulus(pv, pt, pb, pj, ev, et, etg);
      end

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
